// File: rtl/dst_modport.sv
// dst_modport: destination-side output port of the 1x3 router.
// Buffers core bytes (plus header marker) in a FIFO, presents them to the
// reader through valid_out / read_enb / data_out, and tracks packet length.
// Optional feature: define DST_TIMEOUT_EN to build the read-timeout flush
// (soft_reset); when undefined soft_reset is tied low.
module dst_modport #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned TIMEOUT = 30
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             write_enb,
    input  logic             lfd_state,
    input  logic [WIDTH-1:0] data_in,
    input  logic             read_enb,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    output logic             full,
    output logic             empty,
    output logic             soft_reset
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned CW   = AW + 1;
    // Header length field is data[WIDTH-1:2]; one extra bit holds length+1.
    localparam int unsigned PKTW = WIDTH - 1;

    logic [WIDTH:0]     mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic [PKTW-1:0]    pkt_q, pkt_d;
    logic [WIDTH-1:0]   data_out_q, data_out_d;

    logic               do_wr, do_rd, flush;
    logic [WIDTH:0]     rd_entry;
    logic               rd_hdr;
    logic [WIDTH-1:0]   rd_byte;

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign valid_out = ~empty;
    assign data_out  = data_out_q;

    // A write coinciding with a flush is discarded along with the buffer.
    assign do_wr = write_enb & ~full & ~flush;
    assign do_rd = read_enb & ~empty;

    assign rd_entry = mem_q[rd_ptr_q];
    assign rd_hdr   = rd_entry[WIDTH];
    assign rd_byte  = rd_entry[WIDTH-1:0];

`ifdef DST_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] timeout_q;
    logic          soft_reset_q;

    assign flush      = valid_out & ~read_enb & (timeout_q == TW'(TIMEOUT - 1));
    assign soft_reset = soft_reset_q;

    // Count consecutive cycles where data waits unread; pulse soft_reset on expiry.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            timeout_q    <= '0;
            soft_reset_q <= 1'b0;
        end else begin
            soft_reset_q <= flush;
            if (flush) begin
                timeout_q <= '0;
            end else if (valid_out && !read_enb) begin
                timeout_q <= timeout_q + TW'(1);
            end else begin
                timeout_q <= '0;
            end
        end
    end
`else
    assign flush      = 1'b0;
    assign soft_reset = 1'b0;
`endif

    // Storage array; contents need no reset since pointers define validity.
    always_ff @(posedge clock) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= {lfd_state, data_in};
        end
    end

    // Next-state for pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Next-state for read data and packet byte counter.
    always_comb begin
        pkt_d      = pkt_q;
        data_out_d = data_out_q;
        if (flush) begin
            pkt_d      = '0;
            data_out_d = '0;
        end else if (do_rd) begin
            if (rd_hdr) begin
                // Payload length plus the trailing parity byte.
                pkt_d      = {1'b0, rd_byte[WIDTH-1:2]} + PKTW'(1);
                data_out_d = rd_byte;
            end else if (pkt_q == '0) begin
                // Bytes outside any packet are suppressed.
                data_out_d = '0;
            end else begin
                pkt_d      = pkt_q - PKTW'(1);
                data_out_d = rd_byte;
            end
        end
    end

    // State registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            pkt_q      <= '0;
            data_out_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            pkt_q      <= pkt_d;
            data_out_q <= data_out_d;
        end
    end

endmodule

// File: tb/tb_dst_modport.sv
// Self-checking bench for dst_modport: table-driven packet vectors plus a
// scoreboard for full, simultaneous, wrap-around, timeout and reset cases.
module tb_dst_modport;

    localparam int DEPTH = 16;

    logic       clock;
    logic       resetn;
    logic       write_enb;
    logic       lfd_state;
    logic [7:0] data_in;
    logic       read_enb;
    logic [7:0] data_out;
    logic       valid_out;
    logic       full;
    logic       empty;
    logic       soft_reset;

    int checks = 0;
    int errors = 0;

    // Scoreboard of {header bit, byte} and reference packet counter.
    logic [8:0] sb_q [$];
    int         pkt  = 0;

    typedef struct {
        logic       we;
        logic       lfd;
        logic [7:0] din;
        logic       re;
        logic       chk_d;
        logic [7:0] exp_d;
        logic       exp_valid;
        logic       exp_empty;
        logic       exp_full;
    } vec_t;

    vec_t tbl [13];

    dst_modport dut (
        .clock      (clock),
        .resetn     (resetn),
        .write_enb  (write_enb),
        .lfd_state  (lfd_state),
        .data_in    (data_in),
        .read_enb   (read_enb),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .full       (full),
        .empty      (empty),
        .soft_reset (soft_reset)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock cycle: drive inputs, update the reference, sample at edge+1.
    task automatic step(input logic we, input logic lfd, input logic [7:0] d, input logic re);
        logic       do_rd, do_wr;
        logic [8:0] ent;
        logic [7:0] exp_d;
        write_enb = we;
        lfd_state = lfd;
        data_in   = d;
        read_enb  = re;
        do_rd = re && (sb_q.size() > 0);
        do_wr = we && (sb_q.size() < DEPTH);
        exp_d = 8'h00;
        if (do_rd) begin
            ent = sb_q.pop_front();
            if (ent[8]) begin
                pkt   = int'(ent[7:2]) + 1;
                exp_d = ent[7:0];
            end else if (pkt == 0) begin
                exp_d = 8'h00;
            end else begin
                pkt   = pkt - 1;
                exp_d = ent[7:0];
            end
        end
        if (do_wr) sb_q.push_back({lfd, d});
        @(posedge clock);
        #1;
        if (do_rd) chk("sb_dout", data_out, exp_d);
        chk("sb_empty", empty, sb_q.size() == 0);
        chk("sb_full", full, sb_q.size() == DEPTH);
        chk("sb_valid", valid_out, sb_q.size() != 0);
    endtask

`ifdef DST_TIMEOUT_EN
    // Three writes then idle; optional read at read_at; flush expected at flush_at.
    task automatic timeout_run(input int read_at, input int flush_at);
        for (int e = 1; e <= flush_at + 1; e++) begin
            write_enb = (e <= 3) || (e == flush_at);
            lfd_state = (e == 1);
            data_in   = (e == 1) ? 8'h08 : 8'(8'h70 + e);
            read_enb  = (e == read_at);
            @(posedge clock);
            #1;
            if (e == read_at) chk("to_read_dout", data_out, 8'h08);
            if (e == flush_at) begin
                chk("to_soft_reset_hi", soft_reset, 1'b1);
                chk("to_empty", empty, 1'b1);
                chk("to_valid", valid_out, 1'b0);
                chk("to_dout", data_out, 8'h00);
            end else begin
                chk($sformatf("to_soft_reset_lo_%0d", e), soft_reset, 1'b0);
            end
        end
        write_enb = 1'b0;
        read_enb  = 1'b0;
        sb_q.delete();
        pkt = 0;
    endtask
`endif

    initial begin
        tbl[0]  = '{1'b1, 1'b1, 8'h0C, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 8'h11, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 8'h22, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 8'h33, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 8'h3F, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h0C, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h22, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h33, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h3F, 1'b0, 1'b1, 1'b0};
        // Read while empty holds data_out.
        tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h3F, 1'b0, 1'b1, 1'b0};
        // Byte outside a packet reads back as zero.
        tbl[11] = '{1'b1, 1'b0, 8'h55, 1'b0, 1'b1, 8'h3F, 1'b1, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0};

        resetn    = 1'b0;
        write_enb = 1'b0;
        lfd_state = 1'b0;
        data_in   = 8'h00;
        read_enb  = 1'b0;
        #3;
        chk("rst_empty", empty, 1'b1);
        chk("rst_full", full, 1'b0);
        chk("rst_valid", valid_out, 1'b0);
        chk("rst_dout", data_out, 8'h00);
        chk("rst_soft_reset", soft_reset, 1'b0);
        repeat (2) @(negedge clock);
        resetn = 1'b1;

        // Packet vectors.
        for (int i = 0; i < 13; i++) begin
            step(tbl[i].we, tbl[i].lfd, tbl[i].din, tbl[i].re);
            if (tbl[i].chk_d) chk($sformatf("tbl%0d_dout", i), data_out, tbl[i].exp_d);
            chk($sformatf("tbl%0d_valid", i), valid_out, tbl[i].exp_valid);
            chk($sformatf("tbl%0d_empty", i), empty, tbl[i].exp_empty);
            chk($sformatf("tbl%0d_full", i), full, tbl[i].exp_full);
        end

        // Fill to full; the 17th write (AA) must be dropped.
        step(1'b1, 1'b1, 8'h38, 1'b0);
        for (int i = 0; i < 15; i++) step(1'b1, 1'b0, 8'(8'h40 + i), 1'b0);
        chk("full_flag", full, 1'b1);
        step(1'b1, 1'b0, 8'hAA, 1'b0);
        chk("full_after_drop", full, 1'b1);
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("full_drained", empty, 1'b1);

        // Simultaneous read and write at occupancy 5.
        step(1'b1, 1'b1, 8'hFC, 1'b0);
        for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, 8'(i), 1'b0);
        step(1'b1, 1'b0, 8'h05, 1'b1);
        chk("simul_dout", data_out, 8'hFC);

        // Interleaved traffic across pointer wrap, occupancy kept in 1..15.
        for (int i = 0; i < 40; i++) begin
            logic we, re;
            we = (sb_q.size() < 15) ? 1'($urandom_range(1)) : 1'b0;
            re = (sb_q.size() > 1)  ? 1'($urandom_range(1)) : 1'b0;
            step(we, 1'b0, 8'(8'h80 + i), re);
        end
        for (int i = 0; i < DEPTH && sb_q.size() > 0; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("wrap_drained", empty, 1'b1);

`ifdef DST_TIMEOUT_EN
        timeout_run(0, 31);
        timeout_run(30, 60);
`else
        step(1'b1, 1'b1, 8'h08, 1'b0);
        step(1'b1, 1'b0, 8'h71, 1'b0);
        step(1'b1, 1'b0, 8'h72, 1'b0);
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 1'b0, 8'h00, 1'b0);
            chk("no_to_soft_reset", soft_reset, 1'b0);
        end
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
`endif

        // Asynchronous reset in mid-traffic.
        step(1'b1, 1'b1, 8'h10, 1'b0);
        step(1'b1, 1'b0, 8'h21, 1'b1);
        step(1'b1, 1'b0, 8'h22, 1'b0);
        chk("mid_pre_dout", data_out, 8'h10);
        #2;
        resetn = 1'b0;
        #1;
        chk("mid_rst_empty", empty, 1'b1);
        chk("mid_rst_full", full, 1'b0);
        chk("mid_rst_valid", valid_out, 1'b0);
        chk("mid_rst_dout", data_out, 8'h00);
        chk("mid_rst_soft_reset", soft_reset, 1'b0);
        write_enb = 1'b0;
        read_enb  = 1'b0;
        sb_q.delete();
        pkt = 0;
        @(negedge clock);
        resetn = 1'b1;
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("post_rst_dout", data_out, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dst_modport.md
Name: dst_modport

Overview:
- Destination-side output port of the 1x3 router: one per output channel.
- Buffers bytes written by the router core in a FIFO and presents them to the external reader via the valid_out / read_enb / data_out handshake.
- Tracks packet boundaries using a header marker and the header length field.
- Supports an optional read-timeout flush (soft reset).

Parameters:
- DEPTH, 16, FIFO entries; power of two, at least 4.
- WIDTH, 8, data byte width.
- TIMEOUT, 30, consecutive unread-valid cycles before a soft reset.

Ports:
- clock  input  1  rising-edge clock.
- resetn  input  1  asynchronous active-low reset.
- write_enb  input  1  core write strobe.
- lfd_state  input  1  marks the byte written this cycle as a packet header.
- data_in  input  WIDTH  byte from the router core.
- read_enb  input  1  reader request.
- data_out  output  WIDTH  registered read data.
- valid_out  output  1  FIFO holds at least one byte.
- full  output  1  FIFO full.
- empty  output  1  FIFO empty.
- soft_reset  output  1  one-cycle pulse on timeout flush.

Behaviour:
- One clock; reset is asynchronous and active-low (clock, resetn).
- While resetn=0:
  - Pointers and occupancy count cleared.
  - data_out=0, full=0, empty=1, valid_out=0, soft_reset=0.
  - Timeout counter and packet counter cleared.
- Storage:
  - DEPTH entries of WIDTH+1 bits; the extra bit stores lfd_state.
  - Occupancy counter is log2(DEPTH)+1 bits wide.
  - Pointers wrap modulo DEPTH.
- Write: on a clock edge with write_enb=1 and full=0, {lfd_state, data_in} is stored at the write pointer, which then increments. A write while full is dropped silently.
- Read:
  - On a clock edge with read_enb=1 and empty=0, data_out is updated from the read pointer, which then increments.
  - Latency is one cycle: the byte appears on data_out at the edge after read_enb is sampled.
  - A read while empty leaves data_out unchanged.
- Simultaneous read and write:
  - Both may occur in the same cycle; occupancy is unchanged.
  - When full, the read proceeds and the write is dropped, because full is evaluated from pre-edge state.
  - When empty, the write proceeds and the read is ignored.
- Flags are combinational from occupancy:
  - full when occupancy = DEPTH.
  - empty when occupancy = 0.
  - valid_out = ~empty.
- Packet counter:
  - When the byte read has its header bit set, load the counter with data[7:2]+1 (payload length plus parity byte).
  - Each subsequent read of a non-header byte decrements the counter, saturating at 0.
  - When the counter is 0 and no header is being read, data_out is forced to 0 on the next read.
- Timeout:
  - Counter increments each cycle with valid_out=1 and read_enb=0.
  - Counter clears on any cycle with read_enb=1 or valid_out=0.
  - When the counter reaches TIMEOUT-1, on the next edge soft_reset=1 for exactly one cycle, the FIFO pointers, occupancy, packet counter and timeout counter clear, and data_out becomes 0.
  - A write in the same cycle as the flush is discarded.
- Asserting resetn mid-packet aborts everything immediately; no partial state survives.

Optional Feature:
- Macro: DST_TIMEOUT_EN.
- Defined: timeout counter and soft-reset flush as described above.
- Undefined: no timeout logic is generated, soft_reset is tied to 0, and the FIFO only clears on resetn.

Test Plan:
- Reset: resetn=0 mid-traffic -> empty=1, full=0, valid_out=0, data_out=0 immediately (asynchronous).
- Packet: write header 8'h0C (length 3, lfd=1), then 8'h11, 8'h22, 8'h33 and parity 8'h3F; assert read_enb for 5 cycles -> data_out = 0C, 11, 22, 33, 3F, each one cycle after read_enb; valid_out falls after the last read.
- Full: 16 writes -> full=1. A 17th write with value 8'hAA is dropped. Reading all 16 returns the original order, with no AA.
- Simultaneous: at occupancy 5, write and read together -> occupancy stays 5, the oldest byte is output and the new byte is stored at the tail.
- Wrap-around: 40 interleaved writes and reads with occupancy between 1 and 15 -> data returned in order across pointer wrap.
- Timeout (DST_TIMEOUT_EN): write 3 bytes, hold read_enb=0 for 30 cycles -> soft_reset pulses 1 cycle, then empty=1 and valid_out=0. A read_enb pulse at cycle 29 restarts the count and gives no soft_reset.
